// File: rtl/tl_ul_port_buffer.sv
// tl_ul_port_buffer: registered TL-UL A/D buffer stage with independent
// channel FIFOs and an outstanding-request throttle with idle reporting.
module tl_ul_port_buffer #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int ADDR_W  = 15,
    parameter int SRC_W   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [2:0]        a_in_opcode,
    input  logic [2:0]        a_in_param,
    input  logic [2:0]        a_in_size,
    input  logic [SRC_W-1:0]  a_in_source,
    input  logic [ADDR_W-1:0] a_in_address,
    input  logic [3:0]        a_in_mask,
    input  logic [31:0]       a_in_data,
    input  logic              a_in_corrupt,
    output logic              a_out_valid,
    input  logic              a_out_ready,
    output logic [2:0]        a_out_opcode,
    output logic [2:0]        a_out_param,
    output logic [2:0]        a_out_size,
    output logic [SRC_W-1:0]  a_out_source,
    output logic [ADDR_W-1:0] a_out_address,
    output logic [3:0]        a_out_mask,
    output logic [31:0]       a_out_data,
    output logic              a_out_corrupt,
    input  logic              d_in_valid,
    output logic              d_in_ready,
    input  logic [2:0]        d_in_opcode,
    input  logic [2:0]        d_in_param,
    input  logic [2:0]        d_in_size,
    input  logic [SRC_W-1:0]  d_in_source,
    input  logic              d_in_denied,
    input  logic [31:0]       d_in_data,
    input  logic              d_in_corrupt,
    output logic              d_out_valid,
    input  logic              d_out_ready,
    output logic [2:0]        d_out_opcode,
    output logic [2:0]        d_out_param,
    output logic [2:0]        d_out_size,
    output logic [SRC_W-1:0]  d_out_source,
    output logic              d_out_denied,
    output logic [31:0]       d_out_data,
    output logic              d_out_corrupt,
    output logic              idle
);
    localparam int AW  = 9 + SRC_W + ADDR_W + 4 + 32 + 1;
    localparam int DW  = 9 + SRC_W + 1 + 32 + 1;
    localparam int APW = $clog2(A_DEPTH);
    localparam int ACW = $clog2(A_DEPTH + 1);
    localparam int DPW = $clog2(D_DEPTH);
    localparam int DCW = $clog2(D_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUT + 1);

    logic [AW-1:0]  a_mem_q [A_DEPTH];
    logic [APW-1:0] a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
    logic [ACW-1:0] a_cnt_q, a_cnt_d;
    logic [DW-1:0]  d_mem_q [D_DEPTH];
    logic [DPW-1:0] d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d;
    logic [DCW-1:0] d_cnt_q, d_cnt_d;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;
    logic           a_push, a_pop, d_push, d_pop;

    assign a_in_ready  = (a_cnt_q != ACW'(A_DEPTH)) && !reset;
    assign d_in_ready  = (d_cnt_q != DCW'(D_DEPTH)) && !reset;
    // Throttle holds A back while MAX_OUT requests await their responses
    assign a_out_valid = (a_cnt_q != '0) && (out_cnt_q != OCW'(MAX_OUT));
    assign d_out_valid = (d_cnt_q != '0);
    assign a_push      = a_in_valid && a_in_ready;
    assign d_push      = d_in_valid && d_in_ready;
    assign a_pop       = a_out_valid && a_out_ready;
    assign d_pop       = d_out_valid && d_out_ready;
    assign idle        = (a_cnt_q == '0) && (d_cnt_q == '0) && (out_cnt_q == '0);

    assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_mem_q[a_rptr_q];
    assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_denied, d_out_data, d_out_corrupt} = d_mem_q[d_rptr_q];

    always_comb begin
        a_wptr_d  = a_push ? a_wptr_q + APW'(1) : a_wptr_q;
        a_rptr_d  = a_pop ? a_rptr_q + APW'(1) : a_rptr_q;
        d_wptr_d  = d_push ? d_wptr_q + DPW'(1) : d_wptr_q;
        d_rptr_d  = d_pop ? d_rptr_q + DPW'(1) : d_rptr_q;
        a_cnt_d   = a_cnt_q;
        d_cnt_d   = d_cnt_q;
        out_cnt_d = out_cnt_q;
        case ({a_push, a_pop})
            2'b10:   a_cnt_d = a_cnt_q + ACW'(1);
            2'b01:   a_cnt_d = a_cnt_q - ACW'(1);
            default: a_cnt_d = a_cnt_q;
        endcase
        case ({d_push, d_pop})
            2'b10:   d_cnt_d = d_cnt_q + DCW'(1);
            2'b01:   d_cnt_d = d_cnt_q - DCW'(1);
            default: d_cnt_d = d_cnt_q;
        endcase
        // A response with nothing outstanding saturates instead of wrapping
        case ({a_pop, d_pop})
            2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
            2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - OCW'(1) : '0;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < A_DEPTH; i++) a_mem_q[i] <= '0;
            for (int i = 0; i < D_DEPTH; i++) d_mem_q[i] <= '0;
            a_wptr_q  <= '0;
            a_rptr_q  <= '0;
            a_cnt_q   <= '0;
            d_wptr_q  <= '0;
            d_rptr_q  <= '0;
            d_cnt_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            if (a_push) begin
                a_mem_q[a_wptr_q] <= {a_in_opcode, a_in_param, a_in_size, a_in_source,
                                      a_in_address, a_in_mask, a_in_data, a_in_corrupt};
            end
            if (d_push) begin
                d_mem_q[d_wptr_q] <= {d_in_opcode, d_in_param, d_in_size, d_in_source,
                                      d_in_denied, d_in_data, d_in_corrupt};
            end
            a_wptr_q  <= a_wptr_d;
            a_rptr_q  <= a_rptr_d;
            a_cnt_q   <= a_cnt_d;
            d_wptr_q  <= d_wptr_d;
            d_rptr_q  <= d_rptr_d;
            d_cnt_q   <= d_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    a_no_orphan_d: assert property (@(posedge clock) disable iff (reset)
        d_pop |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_tl_ul_port_buffer.sv
// Directed self-checking bench for tl_ul_port_buffer: reset, single beat,
// backpressure, throttle, streaming, mid-run reset and denied/corrupt D.
module tb_tl_ul_port_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_in_valid, a_in_ready, a_in_corrupt;
    logic [2:0]  a_in_opcode, a_in_param, a_in_size;
    logic [1:0]  a_in_source;
    logic [14:0] a_in_address;
    logic [3:0]  a_in_mask;
    logic [31:0] a_in_data;
    logic        a_out_valid, a_out_ready, a_out_corrupt;
    logic [2:0]  a_out_opcode, a_out_param, a_out_size;
    logic [1:0]  a_out_source;
    logic [14:0] a_out_address;
    logic [3:0]  a_out_mask;
    logic [31:0] a_out_data;
    logic        d_in_valid, d_in_ready, d_in_denied, d_in_corrupt;
    logic [2:0]  d_in_opcode, d_in_param, d_in_size;
    logic [1:0]  d_in_source;
    logic [31:0] d_in_data;
    logic        d_out_valid, d_out_ready, d_out_denied, d_out_corrupt;
    logic [2:0]  d_out_opcode, d_out_param, d_out_size;
    logic [1:0]  d_out_source;
    logic [31:0] d_out_data;
    logic        idle;
    int          total = 0;
    int          bad = 0;

    tl_ul_port_buffer dut (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
        .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
        .a_in_source(a_in_source), .a_in_address(a_in_address), .a_in_mask(a_in_mask),
        .a_in_data(a_in_data), .a_in_corrupt(a_in_corrupt),
        .a_out_valid(a_out_valid), .a_out_ready(a_out_ready),
        .a_out_opcode(a_out_opcode), .a_out_param(a_out_param), .a_out_size(a_out_size),
        .a_out_source(a_out_source), .a_out_address(a_out_address), .a_out_mask(a_out_mask),
        .a_out_data(a_out_data), .a_out_corrupt(a_out_corrupt),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
        .d_in_source(d_in_source), .d_in_denied(d_in_denied), .d_in_data(d_in_data),
        .d_in_corrupt(d_in_corrupt),
        .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .d_out_opcode(d_out_opcode), .d_out_param(d_out_param), .d_out_size(d_out_size),
        .d_out_source(d_out_source), .d_out_denied(d_out_denied), .d_out_data(d_out_data),
        .d_out_corrupt(d_out_corrupt),
        .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_opcode = 0; a_in_param = 0; a_in_size = 0;
        a_in_source = 0; a_in_address = 0; a_in_mask = 0; a_in_data = 0;
        a_in_corrupt = 0; a_out_ready = 0;
        d_in_valid = 0; d_in_opcode = 0; d_in_param = 0; d_in_size = 0;
        d_in_source = 0; d_in_denied = 0; d_in_data = 0; d_in_corrupt = 0;
        d_out_ready = 0;
        tick();
        tick();
        // Reset state
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_d_in_ready", d_in_ready, 0);
        chk("rst_valids", {a_out_valid, d_out_valid}, 0);
        chk("rst_idle", idle, 1);
        chk("rst_data", {a_out_data, d_out_data}, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {a_in_ready, d_in_ready}, 2'b11);
        chk("post_rst_valid", {a_out_valid, d_out_valid}, 0);
        chk("post_rst_idle", idle, 1);

        // Single Put
        a_in_valid = 1; a_in_opcode = 0; a_in_size = 2; a_in_source = 1;
        a_in_address = 15'h1A4; a_in_mask = 4'hF; a_in_data = 32'hDEADBEEF;
        tick();
        a_in_valid = 0;
        chk("t1_valid", a_out_valid, 1);
        chk("t1_fields", {a_out_opcode, a_out_param, a_out_size, a_out_source,
                          a_out_address, a_out_mask, a_out_data, a_out_corrupt},
            {3'd0, 3'd0, 3'd2, 2'd1, 15'h1A4, 4'hF, 32'hDEADBEEF, 1'b0});
        chk("t1_idle_busy", idle, 0);
        a_out_ready = 1;
        tick();
        chk("t1_a_drained", a_out_valid, 0);
        chk("t1_idle_outst", idle, 0);
        d_in_valid = 1; d_in_source = 1; d_in_data = 32'h0;
        tick();
        d_in_valid = 0;
        chk("t1_d_valid", {d_out_valid, d_out_source}, {1'b1, 2'd1});
        chk("t1_idle_d", idle, 0);
        d_out_ready = 1;
        tick();
        chk("t1_d_drained", d_out_valid, 0);
        chk("t1_idle_back", idle, 1);

        // Backpressure and full
        a_out_ready = 0; a_in_valid = 1; a_in_data = 1;
        tick();
        chk("t2_ready_1", a_in_ready, 1);
        a_in_data = 2;
        tick();
        chk("t2_full", a_in_ready, 0);
        a_in_data = 3;
        tick();
        chk("t2_head", {a_out_valid, a_out_data}, {1'b1, 32'd1});
        chk("t2_still_full", a_in_ready, 0);
        a_in_valid = 0; a_out_ready = 1;
        tick();
        chk("t2_second", {a_out_valid, a_out_data}, {1'b1, 32'd2});
        chk("t2_ready_again", a_in_ready, 1);
        tick();
        chk("t2_no_third", a_out_valid, 0);
        d_in_valid = 1;
        tick();
        tick();
        d_in_valid = 0;
        tick();
        chk("t2_idle", idle, 1);

        // Throttle at MAX_OUT=2
        a_in_valid = 1; a_in_data = 10;
        tick();
        a_in_data = 11;
        tick();
        a_in_data = 12;
        tick();
        chk("t3_throttled", {a_out_valid, a_out_data}, {1'b0, 32'd12});
        a_in_data = 13;
        tick();
        chk("t3_full", {a_in_ready, a_out_valid}, 2'b00);
        a_in_valid = 0;
        tick();
        chk("t3_hold", a_out_valid, 0);
        d_out_ready = 0; d_in_valid = 1; d_in_data = 32'h55;
        tick();
        d_in_valid = 0;
        chk("t3_d_wait", {d_out_valid, a_out_valid}, 2'b10);
        d_out_ready = 1;
        tick();
        chk("t3_release", {a_out_valid, a_out_data}, {1'b1, 32'd12});
        tick();
        chk("t3_rethrottle", {a_out_valid, a_out_data}, {1'b0, 32'd13});

        // Fill both FIFOs with out_cnt at 2, then reset
        a_in_valid = 1; a_in_data = 14;
        tick();
        a_in_valid = 0; d_out_ready = 0; d_in_valid = 1; d_in_data = 32'h66;
        tick();
        d_in_data = 32'h67;
        tick();
        d_in_valid = 0;
        chk("t5_loaded", {a_in_ready, d_in_ready, a_out_valid, d_out_valid, idle}, 5'b00010);
        a_out_ready = 1; d_out_ready = 1; reset = 1;
        tick();
        chk("t5_in_rst", {a_in_ready, d_in_ready, a_out_valid, d_out_valid, idle}, 5'b00001);
        chk("t5_rst_data", {a_out_data, d_out_data}, 0);
        reset = 0;
        #1;
        chk("t5_ready", {a_in_ready, d_in_ready}, 2'b11);
        tick();
        chk("t5_no_stale", {a_out_valid, d_out_valid, idle}, 3'b001);
        tick();
        chk("t5_no_stale2", {a_out_valid, d_out_valid, idle}, 3'b001);

        // Streaming, D lagging A by one cycle
        for (int c = 0; c <= 64; c++) begin
            a_in_valid = (c < 64);
            a_in_data = 32'(c);
            d_in_valid = (c >= 1);
            d_in_data = 32'h1000 + 32'(c) - 32'd1;
            tick();
            if (c < 64) chk("t4_a_beat", {a_in_ready, a_out_valid, a_out_data}, {2'b11, 32'(c)});
            else chk("t4_a_end", a_out_valid, 0);
            if (c >= 1) chk("t4_d_beat", {d_out_valid, d_out_data}, {1'b1, 32'h1000 + 32'(c) - 32'd1});
        end
        a_in_valid = 0; d_in_valid = 0;
        tick();
        chk("t4_idle", {a_out_valid, d_out_valid, idle}, 3'b001);

        // Corrupt A and denied/corrupt D carried verbatim
        a_out_ready = 0; a_in_valid = 1; a_in_corrupt = 1; a_in_data = 32'hCAFE;
        tick();
        a_in_valid = 0; a_in_corrupt = 0;
        chk("t6_a_corrupt", {a_out_valid, a_out_corrupt, a_out_data}, {2'b11, 32'hCAFE});
        a_out_ready = 1;
        tick();
        d_out_ready = 0; d_in_valid = 1; d_in_opcode = 1; d_in_size = 2;
        d_in_source = 2; d_in_denied = 1; d_in_data = 0; d_in_corrupt = 1;
        tick();
        d_in_valid = 0;
        chk("t6_d_fields", {d_out_valid, d_out_opcode, d_out_param, d_out_size, d_out_source,
                            d_out_denied, d_out_data, d_out_corrupt},
            {1'b1, 3'd1, 3'd0, 3'd2, 2'd2, 1'b1, 32'h0, 1'b1});
        chk("t6_idle_busy", idle, 0);
        d_out_ready = 1;
        tick();
        chk("t6_idle", {d_out_valid, idle}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
